// File: rtl/lut_pkg.sv
// Shared types and defaults for the multiport lookup table.
package lut_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } lut_state_e;

   localparam int unsigned LUT_DW_DEF   = 16;
   localparam int unsigned LUT_AW_DEF   = 8;
   localparam int unsigned LUT_NFWD_DEF = 2;

   // Bit offset of lane `lane` inside a flat vector of `width`-bit fields.
   function automatic int unsigned lane_off(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/lut_multiport_if.sv
// Host programming port plus NFWD forwarding read lanes of the lookup table.
interface lut_multiport_if
   import lut_pkg::*;
#(
   parameter int unsigned DW   = LUT_DW_DEF,
   parameter int unsigned AW   = LUT_AW_DEF,
   parameter int unsigned NFWD = LUT_NFWD_DEF
) ();

   logic               host_wren;
   logic               host_rden;
   logic [AW-1:0]      host_addr;
   logic [DW-1:0]      host_wdata;
   logic               host_clr;
   logic [DW-1:0]      host_rdata;
   logic               host_rvalid;
   logic               busy;
   logic               wr_drop;
   logic [NFWD-1:0]    fwd_rden;
   logic [NFWD*AW-1:0] fwd_addr;
   logic [NFWD*DW-1:0] fwd_rdata;
   logic [NFWD-1:0]    fwd_rvalid;

   modport master (
      output host_wren, host_rden, host_addr, host_wdata, host_clr, fwd_rden, fwd_addr,
      input  host_rdata, host_rvalid, busy, wr_drop, fwd_rdata, fwd_rvalid
   );

   modport slave (
      input  host_wren, host_rden, host_addr, host_wdata, host_clr, fwd_rden, fwd_addr,
      output host_rdata, host_rvalid, busy, wr_drop, fwd_rdata, fwd_rvalid
   );

endinterface

// File: rtl/lut_rd_port.sv
// One registered read port: write-first bypass, clear-time INIT override, valid flag.
module lut_rd_port #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rden_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] mem_data_i,
   input  logic          busy_i,
   input  logic [DW-1:0] init_val_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   output logic [DW-1:0] rdata_o,
   output logic          rvalid_o
);

   logic [DW-1:0] rdata_d, rdata_q;
   logic          rvalid_q;

   // The table reads as cleared from the first clear cycle, whatever the sweep has reached.
   always_comb begin
      rdata_d = mem_data_i;
      if (busy_i) begin
         rdata_d = init_val_i;
      end else if (wr_en_i && (wr_addr_i == addr_i)) begin
         rdata_d = wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rden_i;
         if (rden_i) begin
            rdata_q <= rdata_d;
         end
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: rtl/lut_multiport.sv
// Host-programmed lookup table with NFWD parallel forwarding reads and a sequential clear engine.
module lut_multiport
   import lut_pkg::*;
#(
   parameter int unsigned   DW       = LUT_DW_DEF,
   parameter int unsigned   AW       = LUT_AW_DEF,
   parameter int unsigned   NFWD     = LUT_NFWD_DEF,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input logic           clk,
   input logic           rst,
   lut_multiport_if.slave bus
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned NPORT = NFWD + 1;

   logic [DW-1:0] mem_q [DEPTH];

   lut_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          busy;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          wr_acc;
   logic          wr_drop_d, wr_drop_q;

   logic          port_rden   [NPORT];
   logic [AW-1:0] port_addr   [NPORT];
   logic [DW-1:0] port_rdata  [NPORT];
   logic          port_rvalid [NPORT];

   assign busy = (state_q == ST_CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      mem_we    = 1'b0;
      mem_waddr = bus.host_addr;
      mem_wdata = bus.host_wdata;
      wr_acc    = 1'b0;
      wr_drop_d = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = INIT_VAL;
            ptr_d     = ptr_q + 1'b1;
            wr_drop_d = bus.host_wren;
            if (ptr_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.host_clr) begin
               state_d   = ST_CLEAR;
               ptr_d     = '0;
               wr_drop_d = bus.host_wren;
            end else if (bus.host_wren) begin
               wr_acc = 1'b1;
               mem_we = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Port 0 is the host; ports 1..NFWD are the forwarding lanes.
   always_comb begin
      port_rden[0] = bus.host_rden;
      port_addr[0] = bus.host_addr;
      for (int unsigned i = 0; i < NFWD; i++) begin
         port_rden[i+1] = bus.fwd_rden[i];
         port_addr[i+1] = bus.fwd_addr[lane_off(i, AW) +: AW];
      end
   end

   for (genvar g = 0; g < NPORT; g++) begin : g_port
      lut_rd_port #(
         .DW (DW),
         .AW (AW)
      ) u_rd_port (
         .clk        (clk),
         .rst        (rst),
         .rden_i     (port_rden[g]),
         .addr_i     (port_addr[g]),
         .mem_data_i (mem_q[port_addr[g]]),
         .busy_i     (busy),
         .init_val_i (INIT_VAL),
         .wr_en_i    (wr_acc),
         .wr_addr_i  (bus.host_addr),
         .wr_data_i  (bus.host_wdata),
         .rdata_o    (port_rdata[g]),
         .rvalid_o   (port_rvalid[g])
      );
   end

   always_comb begin
      bus.host_rdata  = port_rdata[0];
      bus.host_rvalid = port_rvalid[0];
      bus.fwd_rdata   = '0;
      bus.fwd_rvalid  = '0;
      for (int unsigned i = 0; i < NFWD; i++) begin
         bus.fwd_rdata[lane_off(i, DW) +: DW] = port_rdata[i+1];
         bus.fwd_rvalid[i]                    = port_rvalid[i+1];
      end
   end

   assign bus.busy    = busy;
   assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_lut_multiport.sv
// Two builds (AW=8/NFWD=2 and AW=4/NFWD=4) checked every cycle against a table-level model.
module tb_lut_multiport;

   localparam logic [15:0] INIT_B = 16'h5A5A;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_multiport_if #(.DW(16), .AW(8), .NFWD(2)) bus_a ();
   lut_multiport_if #(.DW(16), .AW(4), .NFWD(4)) bus_b ();

   lut_multiport #(.DW(16), .AW(8), .NFWD(2), .INIT_VAL(16'h0000)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   lut_multiport #(.DW(16), .AW(4), .NFWD(4), .INIT_VAL(INIT_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Model: the table is treated as fully cleared the moment a clear starts.
   int unsigned depth_of [2] = '{256, 16};
   int unsigned nport_of [2] = '{3, 5};
   logic [15:0] init_of  [2];
   logic [15:0] m_mem    [2][256];
   int          m_left   [2];
   logic        m_drop   [2];
   logic [15:0] m_rd     [2][5];
   logic        m_rv     [2][5];

   logic        i_wren, i_clr;
   logic [7:0]  i_waddr;
   logic [15:0] i_wdata;
   logic        i_rden [5];
   logic [7:0]  i_addr [5];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic snap(input int d);
      if (d == 0) begin
         i_wren    = bus_a.host_wren;
         i_clr     = bus_a.host_clr;
         i_waddr   = bus_a.host_addr;
         i_wdata   = bus_a.host_wdata;
         i_rden[0] = bus_a.host_rden;
         i_addr[0] = bus_a.host_addr;
         for (int p = 0; p < 2; p++) begin
            i_rden[p+1] = bus_a.fwd_rden[p];
            i_addr[p+1] = bus_a.fwd_addr[p*8 +: 8];
         end
      end else begin
         i_wren    = bus_b.host_wren;
         i_clr     = bus_b.host_clr;
         i_waddr   = {4'h0, bus_b.host_addr};
         i_wdata   = bus_b.host_wdata;
         i_rden[0] = bus_b.host_rden;
         i_addr[0] = {4'h0, bus_b.host_addr};
         for (int p = 0; p < 4; p++) begin
            i_rden[p+1] = bus_b.fwd_rden[p];
            i_addr[p+1] = {4'h0, bus_b.fwd_addr[p*4 +: 4]};
         end
      end
   endtask

   task automatic model_step(input int d);
      logic busy, acc;
      snap(d);
      busy = (m_left[d] > 0);
      if (rst) begin
         m_left[d] = int'(depth_of[d]);
         m_drop[d] = 1'b0;
         for (int p = 0; p < 5; p++) begin
            m_rv[d][p] = 1'b0;
            m_rd[d][p] = 16'h0000;
         end
         for (int a = 0; a < 256; a++) m_mem[d][a] = init_of[d];
         return;
      end
      m_drop[d] = i_wren && (busy || i_clr);
      acc       = i_wren && !busy && !i_clr;
      for (int p = 0; p < int'(nport_of[d]); p++) begin
         m_rv[d][p] = i_rden[p];
         if (i_rden[p]) begin
            if (busy)                            m_rd[d][p] = init_of[d];
            else if (acc && i_addr[p] == i_waddr) m_rd[d][p] = i_wdata;
            else                                 m_rd[d][p] = m_mem[d][i_addr[p]];
         end
      end
      if (busy) begin
         m_left[d]--;
      end else if (i_clr) begin
         m_left[d] = int'(depth_of[d]);
         for (int a = 0; a < 256; a++) m_mem[d][a] = init_of[d];
      end else if (acc) begin
         m_mem[d][i_waddr] = i_wdata;
      end
   endtask

   task automatic check_outs(input int d);
      logic        o_busy, o_drop;
      logic [15:0] o_rd [5];
      logic        o_rv [5];
      string       pre;
      if (d == 0) begin
         pre = "A";
         o_busy = bus_a.busy;
         o_drop = bus_a.wr_drop;
         o_rd[0] = bus_a.host_rdata;
         o_rv[0] = bus_a.host_rvalid;
         for (int p = 0; p < 2; p++) begin
            o_rd[p+1] = bus_a.fwd_rdata[p*16 +: 16];
            o_rv[p+1] = bus_a.fwd_rvalid[p];
         end
      end else begin
         pre = "B";
         o_busy = bus_b.busy;
         o_drop = bus_b.wr_drop;
         o_rd[0] = bus_b.host_rdata;
         o_rv[0] = bus_b.host_rvalid;
         for (int p = 0; p < 4; p++) begin
            o_rd[p+1] = bus_b.fwd_rdata[p*16 +: 16];
            o_rv[p+1] = bus_b.fwd_rvalid[p];
         end
      end
      check({pre, ".busy"}, 32'(o_busy), 32'(m_left[d] > 0));
      check({pre, ".wr_drop"}, 32'(o_drop), 32'(m_drop[d]));
      for (int p = 0; p < int'(nport_of[d]); p++) begin
         check($sformatf("%s.port%0d.valid", pre, p), 32'(o_rv[p]), 32'(m_rv[d][p]));
         check($sformatf("%s.port%0d.data", pre, p), 32'(o_rd[p]), 32'(m_rd[d][p]));
      end
   endtask

   task automatic cycle();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_outs(0);
      check_outs(1);
   endtask

   task automatic quiet();
      bus_a.host_wren = 1'b0; bus_a.host_rden = 1'b0; bus_a.host_clr = 1'b0;
      bus_a.fwd_rden  = '0;
      bus_b.host_wren = 1'b0; bus_b.host_rden = 1'b0; bus_b.host_clr = 1'b0;
      bus_b.fwd_rden  = '0;
   endtask

   task automatic wait_idle_a(input string tag, output int n);
      n = 0;
      while (bus_a.busy && n < 1000) begin
         cycle();
         n++;
      end
      if (n >= 1000) check({tag, ".timeout"}, 32'(bus_a.busy), 32'd0);
   endtask

   initial begin
      int n;
      init_of[0] = 16'h0000;
      init_of[1] = INIT_B;
      rst = 1'b1;
      quiet();
      bus_a.host_addr = '0; bus_a.host_wdata = '0; bus_a.fwd_addr = '0;
      bus_b.host_addr = '0; bus_b.host_wdata = '0; bus_b.fwd_addr = '0;

      // Reset release and clear length; lane 0 reads 0x10 mid-clear.
      cycle();
      cycle();
      check("t1.reset.valid", 32'(bus_a.fwd_rvalid), 32'd0);
      check("t1.reset.data", 32'(bus_a.host_rdata), 32'd0);
      rst = 1'b0;
      n = 0;
      while (bus_a.busy && n < 1000) begin
         quiet();
         if (n == 5) begin
            bus_a.fwd_rden[0]     = 1'b1;
            bus_a.fwd_addr[7:0]   = 8'h10;
         end
         cycle();
         if (n == 5) begin
            check("t1.midclr.valid", 32'(bus_a.fwd_rvalid[0]), 32'd1);
            check("t1.midclr.data", 32'(bus_a.fwd_rdata[15:0]), 32'h0000);
         end
         n++;
      end
      check("t1.busy_cycles", 32'(n), 32'd256);

      // Write then read back on host and both lanes.
      quiet();
      bus_a.host_wren = 1'b1; bus_a.host_addr = 8'h22; bus_a.host_wdata = 16'hBEEF;
      cycle();
      quiet();
      bus_a.host_rden = 1'b1; bus_a.host_addr = 8'h22;
      bus_a.fwd_rden = 2'b11; bus_a.fwd_addr = {8'h22, 8'h22};
      cycle();
      check("t2.host", 32'(bus_a.host_rdata), 32'hBEEF);
      check("t2.lane0", 32'(bus_a.fwd_rdata[15:0]), 32'hBEEF);
      check("t2.lane1", 32'(bus_a.fwd_rdata[31:16]), 32'hBEEF);
      check("t2.valid", 32'({bus_a.host_rvalid, bus_a.fwd_rvalid}), 32'h7);
      quiet();
      cycle();
      check("t2.hold.valid", 32'({bus_a.host_rvalid, bus_a.fwd_rvalid}), 32'h0);
      check("t2.hold.data", 32'(bus_a.host_rdata), 32'hBEEF);

      // Write-first bypass.
      bus_a.host_wren = 1'b1; bus_a.host_addr = 8'h40; bus_a.host_wdata = 16'h1111;
      cycle();
      bus_a.host_addr = 8'h41; bus_a.host_wdata = 16'h3333;
      cycle();
      bus_a.host_addr = 8'h40; bus_a.host_wdata = 16'h2222;
      bus_a.fwd_rden = 2'b11; bus_a.fwd_addr = {8'h40, 8'h41};
      cycle();
      check("t3.bypass", 32'(bus_a.fwd_rdata[31:16]), 32'h2222);
      check("t3.other", 32'(bus_a.fwd_rdata[15:0]), 32'h3333);

      // Clear, dropped writes, readback of INIT.
      quiet();
      bus_a.host_clr = 1'b1;
      cycle();
      check("t4.busy_rise", 32'(bus_a.busy), 32'd1);
      quiet();
      bus_a.host_wren = 1'b1; bus_a.host_addr = 8'h22; bus_a.host_wdata = 16'h5555;
      cycle();
      check("t4.drop", 32'(bus_a.wr_drop), 32'd1);
      quiet();
      wait_idle_a("t4.wait", n);
      bus_a.host_rden = 1'b1; bus_a.host_addr = 8'h22;
      cycle();
      check("t4.cleared", 32'(bus_a.host_rdata), 32'h0000);
      quiet();
      bus_a.host_clr = 1'b1; bus_a.host_wren = 1'b1;
      bus_a.host_addr = 8'h30; bus_a.host_wdata = 16'h7777;
      cycle();
      check("t4.clr_wr_drop", 32'(bus_a.wr_drop), 32'd1);
      quiet();
      wait_idle_a("t4.wait2", n);

      // Reset at clear cycle 100 restarts the sweep and kills valids.
      bus_a.host_clr = 1'b1;
      cycle();
      quiet();
      for (int k = 0; k < 99; k++) begin
         bus_a.host_rden = 1'b1; bus_a.fwd_rden = 2'b11;
         cycle();
      end
      rst = 1'b1;
      cycle();
      check("t5.rst.valid", 32'({bus_a.host_rvalid, bus_a.fwd_rvalid}), 32'h0);
      check("t5.rst.busy", 32'(bus_a.busy), 32'd1);
      rst = 1'b0;
      quiet();
      wait_idle_a("t5.wait", n);
      check("t5.busy_cycles", 32'(n), 32'd256);

      // Random traffic on both builds.
      for (int k = 0; k < 3000; k++) begin
         bus_a.host_wren  = ($urandom_range(0, 2) == 0);
         bus_a.host_rden  = $urandom_range(0, 1);
         bus_a.host_clr   = ($urandom_range(0, 599) == 0);
         bus_a.host_addr  = 8'($urandom_range(0, 15));
         bus_a.host_wdata = 16'($urandom);
         bus_a.fwd_rden   = 2'($urandom);
         for (int p = 0; p < 2; p++) bus_a.fwd_addr[p*8 +: 8] = 8'($urandom_range(0, 15));
         bus_b.host_wren  = ($urandom_range(0, 2) == 0);
         bus_b.host_rden  = $urandom_range(0, 1);
         bus_b.host_clr   = ($urandom_range(0, 199) == 0);
         bus_b.host_addr  = 4'($urandom);
         bus_b.host_wdata = 16'($urandom);
         bus_b.fwd_rden   = 4'($urandom);
         bus_b.fwd_addr   = 16'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
